// File: rtl/reg_file_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_scoreboard_if
// Brief    : Decode/writeback-facing bundle of the register file scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
interface reg_file_scoreboard_if;
  logic [2:0]  rd_addr_a;
  logic [2:0]  rd_addr_b;
  logic [15:0] rd_data_a;
  logic [15:0] rd_data_b;
  logic        rd_locked_a;
  logic        rd_locked_b;
  logic        lock_reg;
  logic [2:0]  lock_reg_addr;
  logic        lock_full;
  logic        unlock_reg;
  logic [2:0]  unlock_reg_addr;
  logic        write_reg_ctrl;
  logic [2:0]  write_reg_addr;
  logic [15:0] write_reg_data;
  logic        wrsp;
  logic        wrih;
  logic        wrra;
  logic [15:0] sp_reg_data;
  logic        clear_flow;
  logic [15:0] sp;
  logic [15:0] ih;
  logic [15:0] ra;
  logic        lock_err;

  modport master (
    output rd_addr_a, rd_addr_b, lock_reg, lock_reg_addr, unlock_reg,
           unlock_reg_addr, write_reg_ctrl, write_reg_addr, write_reg_data,
           wrsp, wrih, wrra, sp_reg_data, clear_flow,
    input  rd_data_a, rd_data_b, rd_locked_a, rd_locked_b, lock_full,
           sp, ih, ra, lock_err
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, lock_reg, lock_reg_addr, unlock_reg,
           unlock_reg_addr, write_reg_ctrl, write_reg_addr, write_reg_data,
           wrsp, wrih, wrra, sp_reg_data, clear_flow,
    output rd_data_a, rd_data_b, rd_locked_a, rd_locked_b, lock_full,
           sp, ih, ra, lock_err
  );
endinterface
`default_nettype wire

// File: rtl/reg_file_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_scoreboard
// Brief    : R0..R7 + SP/IH/RA register file with per-register pending-write
//            counters; optional same-cycle write bypass via REG_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_scoreboard #(
  parameter logic [15:0] SP_RESET = 16'hBF00,
  parameter int unsigned CNT_W    = 2
) (
  input wire logic             clk,
  input wire logic             rst,
  reg_file_scoreboard_if.slave bus
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  logic [15:0]      r_regs [8];
  logic [CNT_W-1:0] r_cnt  [8];
  logic [15:0]      r_sp;
  logic [15:0]      r_ih;
  logic [15:0]      r_ra;
  logic             r_lock_err;

  logic [7:0]       w_inc;
  logic [7:0]       w_dec;
  logic [CNT_W-1:0] w_cnt_a;
  logic [CNT_W-1:0] w_cnt_b;
  logic [CNT_W-1:0] w_cnt_lock;

  for (genvar gi = 0; gi < 8; gi++) begin : g_dec
    assign w_inc[gi] = bus.lock_reg   && (bus.lock_reg_addr   == 3'(gi));
    assign w_dec[gi] = bus.unlock_reg && (bus.unlock_reg_addr == 3'(gi));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_sp       <= SP_RESET;
      r_ih       <= '0;
      r_ra       <= '0;
      r_lock_err <= 1'b0;
    end else begin
      if (bus.write_reg_ctrl) r_regs[bus.write_reg_addr] <= bus.write_reg_data;
      if (bus.wrsp) r_sp <= bus.sp_reg_data;
      if (bus.wrih) r_ih <= bus.sp_reg_data;
      if (bus.wrra) r_ra <= bus.sp_reg_data;
      // A flush wipes every lock and masks same-cycle lock/unlock requests.
      for (int i = 0; i < 8; i++) begin
        if (bus.clear_flow) begin
          r_cnt[i] <= '0;
        end else if (w_inc[i] && !w_dec[i]) begin
          if (r_cnt[i] != C_CNT_MAX) r_cnt[i] <= r_cnt[i] + C_CNT_ONE;
        end else if (w_dec[i] && !w_inc[i]) begin
          if (r_cnt[i] == '0) r_lock_err <= 1'b1;
          else                r_cnt[i]   <= r_cnt[i] - C_CNT_ONE;
        end
      end
    end
  end

  assign w_cnt_a    = r_cnt[bus.rd_addr_a];
  assign w_cnt_b    = r_cnt[bus.rd_addr_b];
  assign w_cnt_lock = r_cnt[bus.lock_reg_addr];

  // A retiring last write releases the operand in the same cycle.
  assign bus.rd_locked_a = (w_cnt_a != '0) &&
                           !(w_dec[bus.rd_addr_a] && (w_cnt_a == C_CNT_ONE));
  assign bus.rd_locked_b = (w_cnt_b != '0) &&
                           !(w_dec[bus.rd_addr_b] && (w_cnt_b == C_CNT_ONE));
  assign bus.lock_full   = bus.lock_reg && (w_cnt_lock == C_CNT_MAX) &&
                           !w_dec[bus.lock_reg_addr];
  assign bus.lock_err    = r_lock_err;

`ifdef REG_BYPASS_EN
  assign bus.rd_data_a = (bus.write_reg_ctrl && (bus.write_reg_addr == bus.rd_addr_a))
                         ? bus.write_reg_data : r_regs[bus.rd_addr_a];
  assign bus.rd_data_b = (bus.write_reg_ctrl && (bus.write_reg_addr == bus.rd_addr_b))
                         ? bus.write_reg_data : r_regs[bus.rd_addr_b];
  assign bus.sp        = bus.wrsp ? bus.sp_reg_data : r_sp;
  assign bus.ih        = bus.wrih ? bus.sp_reg_data : r_ih;
  assign bus.ra        = bus.wrra ? bus.sp_reg_data : r_ra;
`else
  assign bus.rd_data_a = r_regs[bus.rd_addr_a];
  assign bus.rd_data_b = r_regs[bus.rd_addr_b];
  assign bus.sp        = r_sp;
  assign bus.ih        = r_ih;
  assign bus.ra        = r_ra;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_file_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_scoreboard
// Brief    : Directed + randomized bench for reg_file_scoreboard against an
//            array-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_scoreboard;

  localparam int C_MAXC = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reg_file_scoreboard_if bus ();

  reg_file_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] m_reg [8];
  int          m_cnt [8];
  logic [15:0] m_sp, m_ih, m_ra;
  logic        m_err;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_reg[i] = '0;
      m_cnt[i] = 0;
    end
    m_sp  = 16'hBF00;
    m_ih  = '0;
    m_ra  = '0;
    m_err = 1'b0;
  endtask

  task automatic idle();
    bus.rd_addr_a = '0; bus.rd_addr_b = '0;
    bus.lock_reg = 0; bus.lock_reg_addr = '0;
    bus.unlock_reg = 0; bus.unlock_reg_addr = '0;
    bus.write_reg_ctrl = 0; bus.write_reg_addr = '0; bus.write_reg_data = '0;
    bus.wrsp = 0; bus.wrih = 0; bus.wrra = 0; bus.sp_reg_data = '0;
    bus.clear_flow = 0;
  endtask

  function automatic logic [15:0] exp_rd(input logic [2:0] a);
    logic [15:0] v;
    v = m_reg[a];
`ifdef REG_BYPASS_EN
    if (bus.write_reg_ctrl && bus.write_reg_addr == a) v = bus.write_reg_data;
`endif
    return v;
  endfunction

  function automatic logic [15:0] exp_special(input logic [15:0] stored, input logic wr);
    logic [15:0] v;
    v = stored;
`ifdef REG_BYPASS_EN
    if (wr) v = bus.sp_reg_data;
`else
    if (wr) v = stored;
`endif
    return v;
  endfunction

  function automatic logic exp_locked(input logic [2:0] a);
    return (m_cnt[a] != 0) &&
           !(bus.unlock_reg && bus.unlock_reg_addr == a && m_cnt[a] == 1);
  endfunction

  function automatic logic exp_full();
    return bus.lock_reg && (m_cnt[bus.lock_reg_addr] == C_MAXC) &&
           !(bus.unlock_reg && bus.unlock_reg_addr == bus.lock_reg_addr);
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".rd_data_a"},   32'(bus.rd_data_a),   32'(exp_rd(bus.rd_addr_a)));
    chk({tag, ".rd_data_b"},   32'(bus.rd_data_b),   32'(exp_rd(bus.rd_addr_b)));
    chk({tag, ".rd_locked_a"}, 32'(bus.rd_locked_a), 32'(exp_locked(bus.rd_addr_a)));
    chk({tag, ".rd_locked_b"}, 32'(bus.rd_locked_b), 32'(exp_locked(bus.rd_addr_b)));
    chk({tag, ".lock_full"},   32'(bus.lock_full),   32'(exp_full()));
    chk({tag, ".sp"},          32'(bus.sp),          32'(exp_special(m_sp, bus.wrsp)));
    chk({tag, ".ih"},          32'(bus.ih),          32'(exp_special(m_ih, bus.wrih)));
    chk({tag, ".ra"},          32'(bus.ra),          32'(exp_special(m_ra, bus.wrra)));
    chk({tag, ".lock_err"},    32'(bus.lock_err),    32'(m_err));
  endtask

  // Inputs are stable from posedge+1 through the next posedge.
  task automatic sample(input string tag);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic advance();
    int nc [8];
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      bit inc, dec;
      inc = bus.lock_reg   && bus.lock_reg_addr   == 3'(i);
      dec = bus.unlock_reg && bus.unlock_reg_addr == 3'(i);
      nc[i] = m_cnt[i];
      if (bus.clear_flow)  nc[i] = 0;
      else if (inc && !dec) nc[i] = (m_cnt[i] < C_MAXC) ? m_cnt[i] + 1 : m_cnt[i];
      else if (dec && !inc) begin
        if (m_cnt[i] == 0) m_err = 1'b1;
        else               nc[i] = m_cnt[i] - 1;
      end
    end
    for (int i = 0; i < 8; i++) m_cnt[i] = nc[i];
    if (bus.write_reg_ctrl) m_reg[bus.write_reg_addr] = bus.write_reg_data;
    if (bus.wrsp) m_sp = bus.sp_reg_data;
    if (bus.wrih) m_ih = bus.sp_reg_data;
    if (bus.wrra) m_ra = bus.sp_reg_data;
    #1;
  endtask

  task automatic cycle(input string tag);
    sample(tag);
    advance();
  endtask

  task automatic random_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      bus.rd_addr_a       = 3'($urandom_range(0, 7));
      bus.rd_addr_b       = 3'($urandom_range(0, 7));
      bus.lock_reg        = ($urandom_range(0, 99) < 50);
      bus.lock_reg_addr   = 3'($urandom_range(0, 7));
      bus.unlock_reg      = ($urandom_range(0, 99) < 45);
      bus.unlock_reg_addr = 3'($urandom_range(0, 7));
      bus.write_reg_ctrl  = ($urandom_range(0, 99) < 60);
      bus.write_reg_addr  = 3'($urandom_range(0, 7));
      bus.write_reg_data  = 16'($urandom);
      bus.wrsp            = ($urandom_range(0, 99) < 20);
      bus.wrih            = ($urandom_range(0, 99) < 20);
      bus.wrra            = ($urandom_range(0, 99) < 20);
      bus.sp_reg_data     = 16'($urandom);
      bus.clear_flow      = ($urandom_range(0, 99) < 4);
      if (bus.clear_flow) bus.unlock_reg = 1'b0;
      // Concentrate lock/unlock traffic on few registers to reach saturation.
      if ($urandom_range(0, 1) == 1) begin
        bus.lock_reg_addr   = 3'($urandom_range(0, 1));
        bus.unlock_reg_addr = 3'($urandom_range(0, 1));
        bus.rd_addr_a       = 3'($urandom_range(0, 1));
      end
      cycle("rand");
    end
  endtask

  initial begin
    idle();
    model_reset();
    #12;
    for (int i = 0; i < 8; i++) begin
      bus.rd_addr_a = 3'(i);
      bus.rd_addr_b = 3'(7 - i);
      #1;
      chk("rst.rd_data_a", 32'(bus.rd_data_a), 32'h0);
      chk("rst.rd_locked_a", 32'(bus.rd_locked_a), 32'h0);
    end
    chk("rst.sp", 32'(bus.sp), 32'hBF00);
    chk("rst.lock_err", 32'(bus.lock_err), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    idle();
    @(posedge clk); #1;
    cycle("post_rst");

    // Two locks on R3, then two unlocks; the second releases immediately.
    bus.lock_reg = 1; bus.lock_reg_addr = 3;
    cycle("lock3a");
    cycle("lock3b");
    idle();
    bus.rd_addr_a = 3; bus.unlock_reg = 1; bus.unlock_reg_addr = 3;
    sample("unlock3a");
    chk("tp2.locked_first_unlock", 32'(bus.rd_locked_a), 32'h1);
    advance();
    sample("unlock3b");
    chk("tp2.locked_last_unlock", 32'(bus.rd_locked_a), 32'h0);
    advance();
    bus.unlock_reg = 0;
    sample("after3");
    chk("tp2.counter_zero", 32'(bus.rd_locked_a), 32'h0);
    advance();

    // Saturate R5.
    idle();
    bus.lock_reg = 1; bus.lock_reg_addr = 5; bus.rd_addr_a = 5;
    cycle("lock5a"); cycle("lock5b"); cycle("lock5c");
    sample("lock5_full");
    chk("tp3.lock_full", 32'(bus.lock_full), 32'h1);
    advance();
    bus.unlock_reg = 1; bus.unlock_reg_addr = 5;
    sample("lock5_both");
    chk("tp3.lock_full_both", 32'(bus.lock_full), 32'h0);
    advance();
    bus.unlock_reg = 0;
    sample("lock5_still");
    chk("tp3.still_saturated", 32'(bus.lock_full), 32'h1);
    advance();

    // Write R2 with a same-cycle read on port B.
    idle();
    bus.rd_addr_b = 2; bus.write_reg_ctrl = 1; bus.write_reg_addr = 2;
    bus.write_reg_data = 16'h1234;
    sample("wr2");
`ifdef REG_BYPASS_EN
    chk("tp4.bypass", 32'(bus.rd_data_b), 32'h1234);
`else
    chk("tp4.old_value", 32'(bus.rd_data_b), 32'h0);
`endif
    advance();
    bus.write_reg_ctrl = 0;
    sample("rd2");
    chk("tp4.new_value", 32'(bus.rd_data_b), 32'h1234);
    advance();

    // Special registers together, then an unlock at zero count.
    idle();
    bus.wrsp = 1; bus.wrih = 1; bus.wrra = 1; bus.sp_reg_data = 16'h00FF;
    cycle("wrspecial");
    idle();
    bus.unlock_reg = 1; bus.unlock_reg_addr = 1;
    sample("sp_after");
    chk("tp5.sp", 32'(bus.sp), 32'h00FF);
    chk("tp5.ih", 32'(bus.ih), 32'h00FF);
    chk("tp5.ra", 32'(bus.ra), 32'h00FF);
    advance();
    idle();
    sample("err_set");
    chk("tp5.lock_err", 32'(bus.lock_err), 32'h1);
    advance();
    sample("err_sticky");
    chk("tp5.lock_err_sticky", 32'(bus.lock_err), 32'h1);
    advance();

    // Flush overrides a same-cycle lock.
    bus.lock_reg = 1; bus.lock_reg_addr = 4; cycle("lock4");
    bus.lock_reg_addr = 6;                   cycle("lock6");
    bus.lock_reg_addr = 7; bus.clear_flow = 1; cycle("flush");
    idle();
    bus.rd_addr_a = 4; bus.rd_addr_b = 6;
    sample("flush46");
    chk("tp6.r4_unlocked", 32'(bus.rd_locked_a), 32'h0);
    chk("tp6.r6_unlocked", 32'(bus.rd_locked_b), 32'h0);
    advance();
    bus.rd_addr_a = 7; bus.rd_addr_b = 5;
    sample("flush75");
    chk("tp6.r7_unlocked", 32'(bus.rd_locked_a), 32'h0);
    chk("tp6.r5_unlocked", 32'(bus.rd_locked_b), 32'h0);
    advance();

    random_cycles(250);

    // Asynchronous reset in the middle of a cycle.
    idle();
    bus.rd_addr_a = 3'($urandom_range(0, 7));
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("arst.rd_data_a", 32'(bus.rd_data_a), 32'h0);
    chk("arst.rd_locked_a", 32'(bus.rd_locked_a), 32'h0);
    chk("arst.sp", 32'(bus.sp), 32'hBF00);
    chk("arst.lock_err", 32'(bus.lock_err), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    random_cycles(250);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/reg_file_scoreboard.md
Name: reg_file_scoreboard

Overview:
Register file and lock scoreboard at the receiving end of the execute/writeback interface. It accepts writeback register writes and unlock requests, and stores the eight 16-bit general registers plus the SP, IH and RA special registers. Per-register pending-write counters let the decode stage detect and stall on hazards. Decode reads two operands per cycle and locks destination registers when it issues an instruction.

Parameters:
SP_RESET, 16'hBF00, SP value after reset
CNT_W, 2, width of each per-register pending-write counter (saturates at 2^CNT_W-1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
rd_addr_a  in  3  operand A register index
rd_addr_b  in  3  operand B register index
rd_data_a  out  16  operand A value (combinational)
rd_data_b  out  16  operand B value (combinational)
rd_locked_a  out  1  operand A has a pending write
rd_locked_b  out  1  operand B has a pending write
lock_reg  in  1  decode issues an instruction writing lock_reg_addr
lock_reg_addr  in  3  register to lock
lock_full  out  1  counter of lock_reg_addr is saturated; decode must stall
unlock_reg  in  1  writeback retires a write to unlock_reg_addr
unlock_reg_addr  in  3  register to unlock
write_reg_ctrl  in  1  general register write enable
write_reg_addr  in  3  general register write index
write_reg_data  in  16  general register write data
wrsp  in  1  write SP from sp_reg_data
wrih  in  1  write IH from sp_reg_data
wrra  in  1  write RA from sp_reg_data
sp_reg_data  in  16  special register write data
clear_flow  in  1  pipeline flush; drop all pending locks
sp  out  16  current SP
ih  out  16  current IH
ra  out  16  current RA
lock_err  out  1  sticky: an unlock arrived at a zero counter

Behaviour:
- Reset, asynchronous while rst=0:
  - R0..R7 = 0; IH = 0; RA = 0; SP = SP_RESET.
  - All counters = 0; lock_err = 0.
  - Combinational outputs follow the reset state.
- Register writes:
  - If write_reg_ctrl=1, R[write_reg_addr] <= write_reg_data at the rising edge.
  - wrsp, wrih and wrra act independently. Any combination may be asserted in the same cycle, and each asserted register loads sp_reg_data.
- Counter update per register i, at each rising edge:
  - inc = lock_reg && lock_reg_addr==i
  - dec = unlock_reg && unlock_reg_addr==i
  - inc && dec: counter unchanged.
  - inc only: counter+1. If already at max, counter holds; decode must have stalled on lock_full, so this case is not a legal request.
  - dec only: counter-1. If the counter is 0, it holds at 0 and lock_err <= 1.
- clear_flow=1: all counters <= 0 at the next edge. This overrides any lock or unlock in the same cycle. The register write in that cycle still occurs. lock_err is unaffected.
- rd_locked_x = (cnt[rd_addr_x] != 0) AND NOT (unlock_reg && unlock_reg_addr==rd_addr_x && cnt[rd_addr_x]==1). A retiring last write therefore releases the operand in the same cycle.
- lock_full = lock_reg && (cnt[lock_reg_addr] == max) && !(unlock_reg && unlock_reg_addr==lock_reg_addr).
- Read data: rd_data_x = R[rd_addr_x], subject to the bypass under the optional feature.
- Latency:
  - Writes and counter changes take effect 1 cycle after the edge.
  - Reads are combinational, 0 cycles.
- Reset asserted mid-operation discards all pending state immediately. No output may glitch to X.

Optional Feature:
Macro REG_BYPASS_EN.
- Defined: a same-cycle write wins on reads. If write_reg_ctrl && write_reg_addr==rd_addr_x, then rd_data_x = write_reg_data. sp, ih and ra outputs likewise show sp_reg_data in a cycle where the corresponding wr* is asserted.
- Undefined: reads always return stored values; a write becomes visible in the cycle after its edge.

Test Plan:
1. Reset, then release rst: R0..R7 read 0, sp=16'hBF00, ih=0, ra=0, all rd_locked=0, lock_err=0.
2. lock R3 twice (counter=2), then unlock R3 with rd_addr_a=3: rd_locked_a stays 1; on the second unlock rd_locked_a=0 in that same cycle, and the counter is 0 after the edge.
3. lock R5 three times (counter=3), then assert lock_reg on R5: lock_full=1 and the counter stays 3. Assert lock and unlock of R5 in one cycle: lock_full=0 and the counter stays 3.
4. Write R2=16'h1234 with rd_addr_b=2 in the same cycle:
   - With REG_BYPASS_EN, rd_data_b=16'h1234 immediately.
   - Without it, rd_data_b shows the old value, then 16'h1234 next cycle.
5. Assert wrsp, wrih and wrra together with sp_reg_data=16'h00FF: after the edge, sp=ih=ra=16'h00FF. Unlock R1 at counter 0: lock_err=1 and stays 1.
6. Lock R4 and R6, then assert clear_flow together with lock_reg on R7: all counters are 0 afterwards (R7 not locked) and all rd_locked=0.
